// File: rtl/pattern_detect_ctrl_if.sv
// Control, configuration and bit-stream bundle for pattern_detect_ctrl.
// With PATTERN_DETECT_CTRL_MASK_EN defined the bundle also carries cfg_mask.
interface pattern_detect_ctrl_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
);
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
`ifdef PATTERN_DETECT_CTRL_MASK_EN
    logic [PAT_W-1:0] cfg_mask;
`endif
    logic             start;
    logic             abort;
    logic             bit_valid;
    logic             bit_in;
    logic             bit_ready;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             busy;
    logic             done;
    logic             cfg_err;

    modport master (
        output cfg_pattern, cfg_len, cfg_overlap, cfg_target,
`ifdef PATTERN_DETECT_CTRL_MASK_EN
        output cfg_mask,
`endif
        output start, abort, bit_valid, bit_in,
        input  bit_ready, match, match_count, busy, done, cfg_err
    );

    modport slave (
        input  cfg_pattern, cfg_len, cfg_overlap, cfg_target,
`ifdef PATTERN_DETECT_CTRL_MASK_EN
        input  cfg_mask,
`endif
        input  start, abort, bit_valid, bit_in,
        output bit_ready, match, match_count, busy, done, cfg_err
    );
endinterface

// File: rtl/pattern_detect_ctrl.sv
// Run-time configurable serial pattern detector with start/abort/done run control.
// Optional don't-care mask compare enabled by defining PATTERN_DETECT_CTRL_MASK_EN.
module pattern_detect_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pattern_detect_ctrl_if.slave  bus
);
    localparam int LEN_W = $clog2(PAT_W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [PAT_W-1:0] pat_reg;
    logic [PAT_W-1:0] hist_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] seen_reg;
    logic             ovl_reg;
    logic [CNT_W-1:0] target_reg;
    logic [CNT_W-1:0] count_reg;
    logic             match_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;

    logic             accept;
    logic             cfg_legal;
    logic             start_take;
    logic             hit;
    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] len_mask;
    logic [PAT_W-1:0] dc_mask;
    logic [PAT_W-1:0] diff;
    logic [LEN_W-1:0] seen_next;
    logic [CNT_W-1:0] count_next;

    assign bus.bit_ready = (state_reg == RUN) && !bus.abort;
    assign accept        = bus.bit_ready && bus.bit_valid;

    assign cfg_legal  = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(PAT_W))
                        && (bus.cfg_target != '0);
    // abort has priority over start, and start is ignored while running
    assign start_take = (state_reg != RUN) && !bus.abort && bus.start && cfg_legal;

    assign hist_next  = {hist_reg[PAT_W-2:0], bus.bit_in};
    assign seen_next  = (seen_reg < len_reg) ? seen_reg + 1'b1 : seen_reg;
    assign count_next = count_reg + 1'b1;

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_len_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_reg);
        end
    endgenerate

`ifdef PATTERN_DETECT_CTRL_MASK_EN
    logic [PAT_W-1:0] mask_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_reg <= '0;
        end else if (start_take) begin
            mask_reg <= bus.cfg_mask;
        end
    end

    assign dc_mask = mask_reg;
`else
    assign dc_mask = '0;
`endif

    // Only positions inside the pattern length and not masked take part
    assign diff = (hist_next ^ pat_reg) & len_mask & ~dc_mask;
    assign hit  = accept && (seen_next >= len_reg) && (diff == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            pat_reg    <= '0;
            hist_reg   <= '0;
            len_reg    <= '0;
            seen_reg   <= '0;
            ovl_reg    <= 1'b0;
            target_reg <= '0;
            count_reg  <= '0;
            match_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            match_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.abort) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                    end else if (bus.start) begin
                        if (start_take) begin
                            state_reg  <= RUN;
                            pat_reg    <= bus.cfg_pattern;
                            len_reg    <= bus.cfg_len;
                            ovl_reg    <= bus.cfg_overlap;
                            target_reg <= bus.cfg_target;
                            hist_reg   <= '0;
                            seen_reg   <= '0;
                            count_reg  <= '0;
                            err_reg    <= 1'b0;
                            busy_reg   <= 1'b1;
                            done_reg   <= 1'b0;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (accept) begin
                        hist_reg <= hist_next;
                        // Non-overlap mode demands a full fresh pattern after a match
                        seen_reg <= (hit && !ovl_reg) ? '0 : seen_next;
                        if (hit) begin
                            match_reg <= 1'b1;
                            count_reg <= count_next;
                            if (count_next == target_reg) begin
                                state_reg <= DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.match       = match_reg;
    assign bus.match_count = count_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.cfg_err     = err_reg;
endmodule

// File: doc/pattern_detect_ctrl.md
# pattern_detect_ctrl

Run-time configurable serial pattern-detection controller for the experiment's bit-stream datapath. It generalises the fixed "101" detector: software loads a pattern of up to PAT_W bits, a length, an overlap mode and a match target. The block then sequences a detection run over a valid/ready bit stream, counts matches and stops itself when the target is reached. It sits between the stimulus/bit source and the status logic, and owns the start/abort/done handshake for a run.

## Interface
- PAT_W, 8, maximum pattern length in bits (≥2)
- CNT_W, 16, width of match target and match counter
- LEN_W (derived, not overridable), $clog2(PAT_W)+1, width of cfg_len
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cfg_pattern  in  PAT_W  pattern; bit [cfg_len-1] is the first bit expected, bit [0] the last
- cfg_len  in  LEN_W  pattern length, legal 1..PAT_W
- cfg_overlap  in  1  1 = overlapping matches, 0 = history cleared after each match
- cfg_target  in  CNT_W  matches required to finish a run, legal ≥1
- start  in  1  single-cycle run request
- abort  in  1  terminate run, return to IDLE
- bit_valid  in  1  bit_in is valid
- bit_in  in  1  serial data bit
- bit_ready  out  1  block accepts a bit this cycle
- match  out  1  one-cycle pulse per detected match
- match_count  out  CNT_W  matches in current/last run
- busy  out  1  state == RUN
- done  out  1  state == DONE
- cfg_err  out  1  last start rejected for illegal config (sticky)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start with legal config latches cfg_* into internal registers, clears history, bits_seen, match_count and cfg_err, and enters RUN. start with cfg_len==0, cfg_len>PAT_W or cfg_target==0 sets cfg_err and stays in IDLE.
- RUN: a bit is accepted when bit_valid && bit_ready. On acceptance:
  - hist <= {hist[PAT_W-2:0], bit_in}.
  - bits_seen increments, saturating at len.
  - A match occurs when, including the new bit, bits_seen ≥ len and the low len bits of the new hist equal the low len bits of the latched pattern.
  - On a match: match_count increments. If cfg_overlap=0, bits_seen clears to 0, so the next match needs len fresh bits.
  - When the incremented count equals the target, next state is DONE.
- DONE: holds match_count. start with legal config begins a new run, with the same rules as IDLE. abort goes to IDLE.
- abort in RUN or DONE goes to IDLE. match_count keeps its value until the next accepted start.
- start in RUN is ignored. Config inputs are sampled only on an accepted start; changes during a run have no effect.
- Simultaneous events:
  - abort and start in the same cycle: abort wins, start is ignored.
  - abort and bit_valid in RUN: bit is not accepted.
- Counter: match_count never exceeds the target, because the run ends at the target.

## Timing
- bit_ready = (state==RUN) && !abort. This is combinational, and the only combinational output.
- match, match_count, busy, done and cfg_err are registered. They reflect a bit accepted in cycle t at cycle t+1.
- Final match bit accepted at t: at t+1, match=1, match_count=target, done=1, busy=0 and bit_ready=0.
- start accepted at t: busy=1 and bit_ready=1 at t+1. The first bit can be accepted at t+1.
- Reset (rst_n=0 at a rising edge) takes effect on that edge:
  - state=IDLE; bit_ready, match, busy, done and cfg_err are 0; match_count=0; hist and bits_seen are 0.
  - A run in progress is discarded without a match pulse.

## Configuration
- PATTERN_DETECT_CTRL_MASK_EN defined:
  - Adds input cfg_mask [PAT_W-1:0], latched on start.
  - Positions with a mask bit of 1 are don't-care in the compare.
  - A mask of all ones within len matches once bits_seen ≥ len.
- Not defined: the port is absent and every compared bit must match exactly.

## Test plan
- pattern=3'b101, len=3, overlap=1, target=8, stream 1,0,1,0,1 -> match pulses after bits 3 and 5; match_count=2; busy stays 1.
- Same config with overlap=0, stream 1,0,1,0,1 -> single match after bit 3; match_count=1.
- pattern=101, len=3, overlap=1, target=2, stream 1,0,1,0,1,1 -> done=1 the cycle after bit 5; bit_ready=0; bit 6 not accepted; match_count=2.
- start with cfg_len=0, then start with cfg_target=0 -> cfg_err=1, busy=0 both times. A following legal start clears cfg_err and sets busy=1.
- In RUN after bits 1,0, assert abort with bit_valid=1, bit_in=1 -> bit_ready=0, no match, IDLE next cycle. Restart and send 1,0,1 -> exactly one match.
- Mid-run rst_n=0 for one cycle after bits 1,0 -> all outputs 0. A following start plus 1 -> no match.
- (MASK_EN) pattern=101, mask=010, len=3, stream 1,1,1 -> match after bit 3.
